// File: rtl/lsu_pmp.sv
// Load/store unit front end with a top-of-range PMP checker.
// Each request is captured, checked for alignment and PMP permission in one
// cycle, issued to memory with a bounded wait for the ack, and answered by a
// one-cycle response carrying the extended load data or the fault status.
module lsu_pmp #(
  parameter int TIMEOUT = 16,
  parameter int NREG    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_wdata,
  input  logic                priv_m,
  input  logic [8*NREG-1:0]   pmp_cfg,
  input  logic [32*NREG-1:0]  pmp_addr,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_fault,
  output logic                resp_misaligned
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            fault_q;
  logic            mis_q;
  logic [CW-1:0]   cnt_q;

  // ---------------------------------------------------------------------
  // Alignment and PMP evaluation on the captured request
  // ---------------------------------------------------------------------
  logic            mis_c;
  logic [1:0]      last_off;
  logic [31:0]     last_addr;
  logic [NREG-1:0] region_hit;
  logic [NREG-1:0] region_r;
  logic [NREG-1:0] region_w;
  logic [NREG-1:0] region_l;
  logic [NREG-1:0] cfg_unused;
  logic            hit;
  logic            hit_r;
  logic            hit_w;
  logic            hit_l;
  logic            allow_c;
  logic            timeout_c;

  assign mis_c = (size_q == 2'b11) ||
                 ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));

  // Offset of the last byte touched; size 11 never reaches the PMP decision.
  assign last_off  = (size_q == 2'b00) ? 2'd0 :
                     (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign last_addr = addr_q + {30'd0, last_off};

  for (genvar gi = 0; gi < NREG; gi++) begin : g_region
    logic [31:0] lo;
    logic [31:0] top;
    assign top = pmp_addr[32*gi +: 32];
    if (gi == 0) begin : g_first
      assign lo = 32'd0;
    end else begin : g_rest
      assign lo = pmp_addr[32*(gi-1) +: 32];
    end
    // Both the first and the last byte must fall inside [lo, top).
    assign region_hit[gi] = pmp_cfg[8*gi+3] && (addr_q >= lo) && (last_addr < top);
    assign region_r[gi]   = pmp_cfg[8*gi+0];
    assign region_w[gi]   = pmp_cfg[8*gi+1];
    assign region_l[gi]   = pmp_cfg[8*gi+7];
    assign cfg_unused[gi] = ^{pmp_cfg[8*gi+2], pmp_cfg[8*gi+4 +: 3]};
  end

  // Lowest-numbered matching region wins: scan downwards so it is applied last.
  always_comb begin
    hit   = 1'b0;
    hit_r = 1'b0;
    hit_w = 1'b0;
    hit_l = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (region_hit[i]) begin
        hit   = 1'b1;
        hit_r = region_r[i];
        hit_w = region_w[i];
        hit_l = region_l[i];
      end
    end
  end

  // Unmatched accesses are open to machine mode only; unlocked regions never
  // restrict machine mode.
  assign allow_c = !hit ? priv_m :
                   (priv_m && !hit_l) ? 1'b1 :
                   (we_q ? hit_w : hit_r);

  assign timeout_c = (cnt_q == CW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = CHECK;
      CHECK:   state_d = (mis_c || !allow_c) ? DONE : ACCESS;
      ACCESS:  if (mem_ack || timeout_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, check result, timeout counter and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            rdata_q <= '0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
          end
        end
        CHECK: begin
          // Misalignment masks the PMP outcome so the two flags stay exclusive.
          mis_q   <= mis_c;
          fault_q <= !mis_c && !allow_c;
          cnt_q   <= '0;
        end
        ACCESS: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
          end else if (timeout_c) begin
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [3:0]  be_c;
  logic [31:0] wlane_c;
  logic [31:0] lane_word;
  logic [31:0] load_c;

  // Lane shaping of the byte enables and store data.
  always_comb begin
    case (size_q)
      2'b00: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wlane_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign lane_word = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_c = uns_q ? {24'd0, lane_word[7:0]}
                              : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_c = uns_q ? {16'd0, lane_word[15:0]}
                              : {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_c = lane_word;
    endcase
  end

  // Output decode from state; everything is zero outside its own state.
  always_comb begin
    req_ready       = (state_q == IDLE);
    mem_req         = (state_q == ACCESS);
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_be          = '0;
    mem_wdata       = '0;
    resp_valid      = (state_q == DONE);
    resp_fault      = (state_q == DONE) && fault_q;
    resp_misaligned = (state_q == DONE) && mis_q;
    resp_rdata      = '0;
    if (state_q == ACCESS) begin
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_we    = we_q;
      mem_be    = be_c;
      mem_wdata = wlane_c;
    end
    if ((state_q == DONE) && !we_q && !fault_q && !mis_q) begin
      resp_rdata = load_c;
    end
  end

endmodule

// File: tb/tb_lsu_pmp.sv
// Self-checking bench for lsu_pmp: directed vector table, hand-written
// reset/timing sequences and randomized traffic against a reference model.
module tb_lsu_pmp;

  localparam int NREG    = 4;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [31:0]        req_wdata;
  logic               priv_m;
  logic [8*NREG-1:0]  pmp_cfg;
  logic [32*NREG-1:0] pmp_addr;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic               mem_ack;
  logic [31:0]        mem_rdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_fault;
  logic               resp_misaligned;

  logic [7:0]  cfg_arr [NREG];
  logic [31:0] top_arr [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_pack
    assign pmp_cfg[8*gi +: 8]   = cfg_arr[gi];
    assign pmp_addr[32*gi +: 32] = top_arr[gi];
  end

  always #5 clk = ~clk;

  lsu_pmp #(.TIMEOUT(TIMEOUT), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .priv_m(priv_m),
    .pmp_cfg(pmp_cfg), .pmp_addr(pmp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_misaligned(resp_misaligned)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Observations from the last transaction.
  int          r_cyc;
  logic        r_ready, r_seen, r_stable, r_fault, r_mis, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        mutate = 1'b0;

  task automatic set_region(input int i, input logic [31:0] top, input logic [7:0] cfg);
    top_arr[i] = top;
    cfg_arr[i] = cfg;
  endtask

  // Issue one request, play the memory (ack after ack_after ACCESS cycles,
  // never if negative), and record what the DUT did.
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic un, input logic [31:0] wd, input logic pm,
                         input int ack_after, input logic [31:0] rd, input logic stray);
    int  acc;
    int  cyc;
    bit  done;
    @(negedge clk);
    r_ready = req_ready;
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
    req_unsigned = un; req_wdata = wd; priv_m = pm;
    mem_ack = 1'b0; mem_rdata = rd;
    r_seen = 1'b0; r_stable = 1'b1; r_cyc = -1;
    r_fault = 1'b0; r_mis = 1'b0; r_rdata = '0;
    r_be = '0; r_addr = '0; r_wdata = '0; r_we = 1'b0;
    acc = 0; done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus: the DUT must work from its captured copy.
    req_valid = 1'b0; req_addr = $urandom; req_we = ~we; req_size = ~sz;
    req_unsigned = ~un; req_wdata = $urandom;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (resp_valid) begin
        r_cyc = cyc; r_rdata = resp_rdata;
        r_fault = resp_fault; r_mis = resp_misaligned;
        done = 1'b1;
      end else begin
        if (mem_req) begin
          if (!r_seen) begin
            r_seen = 1'b1; r_be = mem_be; r_addr = mem_addr;
            r_wdata = mem_wdata; r_we = mem_we;
            if (mutate) for (int i = 0; i < NREG; i++) cfg_arr[i] = 8'h00;
          end else if (mem_be !== r_be || mem_addr !== r_addr ||
                       mem_wdata !== r_wdata || mem_we !== r_we) begin
            r_stable = 1'b0;
          end
          mem_ack = (acc == ack_after);
          acc++;
        end else begin
          mem_ack = stray;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic check_txn(input string nm, input logic [31:0] a, input logic we,
                           input logic [1:0] sz, input logic [31:0] wd,
                           input int ecyc, input logic ef, input logic em,
                           input logic ereq, input logic [3:0] ebe, input logic [31:0] erd);
    longint mask;
    int     off;
    chk({nm, ".ready"},      {31'd0, r_ready}, 32'd1);
    chk({nm, ".resp_cycle"}, r_cyc,            ecyc);
    chk({nm, ".fault"},      {31'd0, r_fault}, {31'd0, ef});
    chk({nm, ".misaligned"}, {31'd0, r_mis},   {31'd0, em});
    chk({nm, ".rdata"},      r_rdata,          erd);
    chk({nm, ".mem_req"},    {31'd0, r_seen},  {31'd0, ereq});
    if (ereq && r_seen) begin
      chk({nm, ".mem_be"},   {28'd0, r_be},    {28'd0, ebe});
      chk({nm, ".mem_addr"}, r_addr,           {a[31:2], 2'b00});
      chk({nm, ".mem_we"},   {31'd0, r_we},    {31'd0, we});
      chk({nm, ".stable"},   {31'd0, r_stable}, 32'd1);
      if (we) begin
        off  = int'(a[1:0]);
        mask = (longint'(1) << (8 * (1 << sz))) - 1;
        chk({nm, ".wdata"}, 32'((longint'(r_wdata) >> (8 * off)) & mask),
            32'(longint'(wd) & mask));
      end
    end
    $display("txn %-12s addr=%08h we=%0d size=%0d -> cyc=%0d req=%0d be=%b fault=%0d mis=%0d rdata=%08h",
             nm, a, we, sz, r_cyc, r_seen, r_be, r_fault, r_mis, r_rdata);
  endtask

  // Reference model: outcome of a request from the access rules directly.
  task automatic model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic un, input logic pm, input int ack,
                       input logic [31:0] rd, output int ecyc, output logic ef,
                       output logic em, output logic ereq, output logic [3:0] ebe,
                       output logic [31:0] erd);
    longint n, first, last, lo, mask, val;
    int     off;
    bit     found, allow;
    n = longint'(1) << sz;
    off = int'(a[1:0]);
    ef = 1'b0; ereq = 1'b0; ebe = '0; erd = '0;
    em = (sz == 2'd3) || ((longint'(a) % n) != 0);
    if (em) begin
      ecyc = 2;
      return;
    end
    first = longint'(a);
    last  = first + n - 1;
    found = 1'b0;
    allow = pm;
    for (int i = 0; i < NREG; i++) begin
      lo = (i == 0) ? 0 : longint'(top_arr[i-1]);
      if (!found && cfg_arr[i][3] && first >= lo && last < longint'(top_arr[i])) begin
        found = 1'b1;
        if (pm && !cfg_arr[i][7]) allow = 1'b1;
        else allow = we ? cfg_arr[i][1] : cfg_arr[i][0];
      end
    end
    if (!allow) begin
      ef = 1'b1;
      ecyc = 2;
      return;
    end
    ereq = 1'b1;
    ebe  = 4'(((longint'(1) << n) - 1) << off);
    if (ack >= 0 && ack < TIMEOUT) begin
      ecyc = 3 + ack;
      if (!we) begin
        mask = (longint'(1) << (8 * n)) - 1;
        val  = (longint'(rd) >> (8 * off)) & mask;
        if (!un && val >= (mask + 1) / 2) val = val - (mask + 1);
        erd = 32'(val);
      end
    end else begin
      ecyc = 2 + TIMEOUT;
      ef = 1'b1;
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] wd;
    logic        pm;
    int          ack;
    logic [31:0] rd;
    logic        stray;
    int          ecyc;
    logic        ef;
    logic        em;
    logic        ereq;
    logic [3:0]  ebe;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int          ecyc, cnt;
    logic        ef, em, ereq;
    logic [3:0]  ebe;
    logic [31:0] erd, a, wd, rd;
    logic        we, un, pm;
    logic [1:0]  sz;
    int          ack, sel;
    logic [31:0] t;
    logic [7:0]  saved [NREG];

    //          name          addr          we    sz    un    wdata         pm    ack rdata          stray cyc f     m     req   be       rdata
    vecs[0]  = '{"u_lb_sext",  32'h0000_0103, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 0,  32'h8012_3456, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b1000, 32'hFFFF_FF80};
    vecs[1]  = '{"u_sw_ronly", 32'h0000_2000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 0,  32'h0,         1'b1, 2,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{"m_sw_unlk",  32'h0000_2000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b1, 0,  32'h0,         1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b1111, 32'h0};
    vecs[3]  = '{"lh_mis",     32'h0000_0005, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0, 0,  32'h0,         1'b0, 2,  1'b0, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{"size11",     32'h0000_0000, 1'b0, 2'd3, 1'b0, 32'h0,        1'b0, 0,  32'h0,         1'b0, 2,  1'b0, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[5]  = '{"lw_ack2",    32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 2,  32'hDEAD_BEEF, 1'b1, 5,  1'b0, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF};
    vecs[6]  = '{"lhu_hi",     32'h0000_0102, 1'b0, 2'd1, 1'b1, 32'h0,        1'b0, 0,  32'h8001_7777, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b1100, 32'h0000_8001};
    vecs[7]  = '{"lh_lo_sext", 32'h0000_0100, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0, 0,  32'h1234_F00F, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b0011, 32'hFFFF_F00F};
    vecs[8]  = '{"u_lb_noR",   32'h0000_3000, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 0,  32'h0,         1'b0, 2,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[9]  = '{"m_lw_lock",  32'h0000_3004, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 0,  32'h0,         1'b0, 2,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{"u_nomatch",  32'h0000_6001, 1'b0, 2'd0, 1'b1, 32'h0,        1'b0, 0,  32'h0000_AB00, 1'b0, 2,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{"m_nomatch",  32'h0000_6001, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 0,  32'h0000_AB00, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_00AB};
    vecs[12] = '{"u_sb_ronly", 32'h0000_0101, 1'b1, 2'd0, 1'b0, 32'h0000_005A, 1'b0, 0,  32'h0,         1'b0, 2,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[13] = '{"m_sb",       32'h0000_0101, 1'b1, 2'd0, 1'b0, 32'h0000_005A, 1'b1, 0,  32'h0,         1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b0010, 32'h0};
    vecs[14] = '{"ack_last",   32'h0000_0200, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 15, 32'h1122_3344, 1'b0, 18, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h1122_3344};
    vecs[15] = '{"timeout",    32'h0000_0200, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, -1, 32'h1122_3344, 1'b0, 18, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0};
    vecs[16] = '{"m_disabled", 32'h0000_4FFE, 1'b0, 2'd1, 1'b0, 32'h0,        1'b1, 0,  32'h7FFF_0000, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b1100, 32'h0000_7FFF};
    vecs[17] = '{"lw_top_edge",32'h0000_0FFC, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 0,  32'h0000_0080, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0080};

    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; priv_m = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    set_region(0, 32'h1000, 8'h09);
    set_region(1, 32'h3000, 8'h09);
    set_region(2, 32'h4000, 8'h88);
    set_region(3, 32'h5000, 8'h00);

    // Reset values while reset is held.
    rst = 1'b1;
    #1;
    chk("rst.req_ready",  {31'd0, req_ready},  32'd1);
    chk("rst.mem_req",    {31'd0, mem_req},    32'd0);
    chk("rst.mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst.mem_addr",   mem_addr,            32'd0);
    chk("rst.mem_be",     {28'd0, mem_be},     32'd0);
    chk("rst.mem_wdata",  mem_wdata,           32'd0);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_rdata", resp_rdata,          32'd0);
    chk("rst.resp_flags", {30'd0, resp_fault, resp_misaligned}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].a, vecs[i].we, vecs[i].sz, vecs[i].un, vecs[i].wd, vecs[i].pm,
              vecs[i].ack, vecs[i].rd, vecs[i].stray);
      check_txn(vecs[i].name, vecs[i].a, vecs[i].we, vecs[i].sz, vecs[i].wd, vecs[i].ecyc,
                vecs[i].ef, vecs[i].em, vecs[i].ereq, vecs[i].ebe, vecs[i].erd);
    end

    // Word straddling the top of region 0 belongs to no region.
    set_region(0, 32'h1002, 8'h09);
    run_txn(32'h1000, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    check_txn("u_straddle", 32'h1000, 1'b0, 2'd2, 32'h0, 2, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_txn(32'h1000, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 0, 32'hA5A5_0001, 1'b0);
    check_txn("m_straddle", 32'h1000, 1'b0, 2'd2, 32'h0, 3, 1'b0, 1'b0, 1'b1, 4'b1111, 32'hA5A5_0001);
    set_region(0, 32'h1000, 8'h09);

    // PMP disabled while the access is already in flight.
    for (int i = 0; i < NREG; i++) saved[i] = cfg_arr[i];
    mutate = 1'b1;
    run_txn(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 1, 32'h55AA_55AA, 1'b0);
    mutate = 1'b0;
    for (int i = 0; i < NREG; i++) cfg_arr[i] = saved[i];
    check_txn("pmp_change", 32'h104, 1'b0, 2'd2, 32'h0, 4, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h55AA_55AA);

    // Reset pulsed in the middle of ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8; req_we = 1'b0; req_size = 2'd2; priv_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!mem_req && cnt < 5) begin
      @(negedge clk);
      cnt++;
    end
    chk("rstacc.reached", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstacc.mem_req",   {31'd0, mem_req},    32'd0);
    chk("rstacc.req_ready", {31'd0, req_ready},  32'd1);
    chk("rstacc.mem_be",    {28'd0, mem_be},     32'd0);
    chk("rstacc.mem_addr",  mem_addr,            32'd0);
    chk("rstacc.resp",      {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req) cnt++;
    end
    chk("rstacc.silent", cnt, 32'd0);
    run_txn(32'h8, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 0, 32'h0BAD_F00D, 1'b0);
    check_txn("after_rst", 32'h8, 1'b0, 2'd2, 32'h0, 3, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0BAD_F00D);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      if (n % 20 == 0) begin
        t = 32'h0;
        for (int i = 0; i < NREG; i++) begin
          t = t + $urandom_range(16, 32'h2000);
          top_arr[i] = t;
          cfg_arr[i] = 8'($urandom_range(0, 255)) & 8'h8B;
          if ($urandom_range(0, 3) != 0) cfg_arr[i][3] = 1'b1;
        end
      end
      a  = $urandom_range(0, 32'h9000);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      we = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      pm = 1'($urandom_range(0, 1));
      wd = $urandom;
      rd = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7)       ack = $urandom_range(0, 3);
      else if (sel == 7) ack = TIMEOUT - 1;
      else if (sel == 8) ack = -1;
      else               ack = $urandom_range(4, TIMEOUT - 2);
      model(a, we, sz, un, pm, ack, rd, ecyc, ef, em, ereq, ebe, erd);
      run_txn(a, we, sz, un, wd, pm, ack, rd, 1'($urandom_range(0, 1)));
      check_txn($sformatf("rnd%0d", n), a, we, sz, wd, ecyc, ef, em, ereq, ebe, erd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
